// File: rtl/sort_out_agu_pkg.sv
// Shared counting-sort package: default geometry, derived widths and the
// read-out FSM state encoding used by the sort address generators.
`ifndef SORT_FUC_MAX_NUM
`define SORT_FUC_MAX_NUM 16
`endif
`ifndef SORT_FUC_BK_NUM
`define SORT_FUC_BK_NUM 4
`endif

package sort_out_agu_pkg;

    localparam int SORT_MAX_NUM_DFLT   = `SORT_FUC_MAX_NUM;
    localparam int SORT_BK_NUM_DFLT    = `SORT_FUC_BK_NUM;
    localparam int SORT_DATA_W_DFLT    = $clog2(SORT_MAX_NUM_DFLT);
    localparam int SORT_BK_DEPTH_W_DFLT = $clog2(SORT_BK_NUM_DFLT);
    localparam int SORT_CNT_MEM_DEPTH_W_DFLT = $clog2(SORT_MAX_NUM_DFLT / SORT_BK_NUM_DFLT);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } sort_out_state_e;

endpackage

// File: rtl/sort_out_agu_val_split.sv
// Value -> {row, bank} decode for the banked count memory; the low bits of a
// value select the bank so consecutive values land in consecutive banks.
module sort_val_split #(
    parameter int DATA_W          = 4,
    parameter int BK_DEPTH_W      = 2,
    parameter int CNT_MEM_DEPTH_W = 2
) (
    input  logic [DATA_W-1:0]          val,
    output logic [CNT_MEM_DEPTH_W-1:0] row,
    output logic [BK_DEPTH_W-1:0]      bank
);

    assign row  = val[DATA_W-1:BK_DEPTH_W];
    assign bank = val[BK_DEPTH_W-1:0];

endmodule

// File: rtl/sort_out_agu.sv
// Counting-sort read-out AGU: walks every value in ascending order, fetches its
// count from the banked count memory and replays the value that many times.
module sort_out_agu
    import sort_out_agu_pkg::*;
#(
    parameter int SORT_FUC_MAX_NUM         = `SORT_FUC_MAX_NUM,
    parameter int SORT_FUC_BK_NUM          = `SORT_FUC_BK_NUM,
    parameter int SORT_FUC_CNT_W           = 16,
    parameter int SORT_FUC_CNT_MEM_DEPTH_W = $clog2(SORT_FUC_MAX_NUM / SORT_FUC_BK_NUM),
    parameter int SORT_FUC_DATA_W          = $clog2(SORT_FUC_MAX_NUM),
    parameter int SORT_FUC_BK_DEPTH_W      = $clog2(SORT_FUC_BK_NUM)
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                out2cnt_vld_o,
    output logic [SORT_FUC_CNT_MEM_DEPTH_W-1:0] out2cnt_addr_o,
    output logic [SORT_FUC_BK_DEPTH_W-1:0]      out2cnt_bankid_o,
    input  logic [SORT_FUC_CNT_W-1:0]           cnt_rdata_i,
    output logic                                sort_vld_o,
    output logic [SORT_FUC_DATA_W-1:0]          sort_data_o,
    input  logic                                sort_rdy_i
);

    localparam logic [SORT_FUC_DATA_W-1:0] V_LAST = SORT_FUC_DATA_W'(SORT_FUC_MAX_NUM - 1);
    localparam logic [SORT_FUC_DATA_W-1:0] V_ONE  = SORT_FUC_DATA_W'(1);
    localparam logic [SORT_FUC_CNT_W-1:0]  REM_ONE = SORT_FUC_CNT_W'(1);

    sort_out_state_e             state_r, state_s;
    logic [SORT_FUC_DATA_W-1:0]  v_r, v_s;
    logic [SORT_FUC_CNT_W-1:0]   rem_r, rem_s;
    logic                        last_v_s;

    assign last_v_s = (v_r == V_LAST);

    // State and counter registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            v_r     <= {SORT_FUC_DATA_W{1'b0}};
            rem_r   <= {SORT_FUC_CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            v_r     <= v_s;
            rem_r   <= rem_s;
        end
    end

    // Next-state and counter update; finishing a value either moves on or ends the scan
    always_comb begin
        state_s = state_r;
        v_s     = v_r;
        rem_s   = rem_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_s = ST_RD;
                    v_s     = {SORT_FUC_DATA_W{1'b0}};
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                rem_s = cnt_rdata_i;
                if (cnt_rdata_i != {SORT_FUC_CNT_W{1'b0}}) begin
                    state_s = ST_EMIT;
                end else if (last_v_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RD;
                    v_s     = v_r + V_ONE;
                end
            end
            ST_EMIT: begin
                if (sort_rdy_i) begin
                    rem_s = rem_r - REM_ONE;
                    if (rem_r != REM_ONE) begin
                        state_s = ST_EMIT;
                    end else if (last_v_s) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RD;
                        v_s     = v_r + V_ONE;
                    end
                end else begin
                    state_s = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of the registered state and value counter
    assign busy_o        = (state_r != ST_IDLE);
    assign done_o        = (state_r == ST_DONE);
    assign out2cnt_vld_o = (state_r == ST_RD);
    assign sort_vld_o    = (state_r == ST_EMIT);
    assign sort_data_o   = v_r;

    sort_val_split #(
        .DATA_W          (SORT_FUC_DATA_W),
        .BK_DEPTH_W      (SORT_FUC_BK_DEPTH_W),
        .CNT_MEM_DEPTH_W (SORT_FUC_CNT_MEM_DEPTH_W)
    ) u_val_split (
        .val  (v_r),
        .row  (out2cnt_addr_o),
        .bank (out2cnt_bankid_o)
    );

endmodule

// File: tb/tb_sort_out_agu.sv
// Self-checking bench for sort_out_agu with MAX_NUM=16, BK_NUM=4 and a
// one-cycle-latency count memory; expected stream built from the count table.
module tb_sort_out_agu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        rdy;
    logic [15:0] cnt_rdata;
    logic        busy, done, rd_vld, sort_vld;
    logic [1:0]  rd_addr, rd_bank;
    logic [3:0]  sort_data;

    logic [15:0] cnt_mem [16];
    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sort_out_agu #(
        .SORT_FUC_MAX_NUM (16),
        .SORT_FUC_BK_NUM  (4),
        .SORT_FUC_CNT_W   (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .busy_o           (busy),
        .done_o           (done),
        .out2cnt_vld_o    (rd_vld),
        .out2cnt_addr_o   (rd_addr),
        .out2cnt_bankid_o (rd_bank),
        .cnt_rdata_i      (cnt_rdata),
        .sort_vld_o       (sort_vld),
        .sort_data_o      (sort_data),
        .sort_rdy_i       (rdy)
    );

    // Count memory: data for a strobed read appears the next cycle, junk otherwise
    always @(posedge clk) begin
        if (rd_vld) cnt_rdata <= cnt_mem[{rd_addr, rd_bank}];
        else        cnt_rdata <= 16'hA5A5;
    end

    task automatic check_idle_outputs(input string name);
        checks++;
        if ({busy, done, rd_vld, sort_vld, rd_addr, rd_bank, sort_data} !== 12'd0) begin
            $display("FAIL %s outputs got busy=%b done=%b rdv=%b sv=%b addr=%0d bank=%0d data=%0d want all 0",
                     name, busy, done, rd_vld, sort_vld, rd_addr, rd_bank, sort_data);
        end else passes++;
    endtask

    // Run one complete scan and compare reads, stream, stalls and done timing
    task automatic run_scan(input string name, input bit rnd_rdy, input int restart_at);
        int exp_q[$];
        int exp_rd = 0;
        int n = 0;
        int done_n = -1;
        int exp_done = 1;
        int budget;
        int ev;
        logic pv = 1'b0;
        logic pr = 1'b0;
        logic [3:0] pd = 4'd0;
        logic [1:0] ea, eb;
        for (int v = 0; v < 16; v++) begin
            exp_done += 2 + int'(cnt_mem[v]);
            for (int k = 0; k < int'(cnt_mem[v]); k++) exp_q.push_back(v);
        end
        budget = rnd_rdy ? (3 * exp_done + 50) : (exp_done + 5);
        @(negedge clk);
        start = 1'b1;
        while (done_n < 0 && n < budget) begin
            @(negedge clk);
            n++;
            start = (n == restart_at);
            if (rd_vld) begin
                ea = 2'(exp_rd >> 2);
                eb = 2'(exp_rd & 3);
                checks++;
                if (exp_rd > 15 || rd_addr !== ea || rd_bank !== eb) begin
                    $display("FAIL %s read got addr=%0d bank=%0d want addr=%0d bank=%0d (read #%0d)",
                             name, rd_addr, rd_bank, ea, eb, exp_rd);
                end else passes++;
                checks++;
                if (exp_q.size() != 0 && exp_q[0] < exp_rd) begin
                    $display("FAIL %s read_order read v=%0d issued with value %0d still pending",
                             name, exp_rd, exp_q[0]);
                end else passes++;
                exp_rd++;
            end
            if (pv && !pr) begin
                checks++;
                if (sort_vld !== 1'b1 || sort_data !== pd) begin
                    $display("FAIL %s stall got vld=%b data=%0d want vld=1 data=%0d",
                             name, sort_vld, sort_data, pd);
                end else passes++;
            end
            rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sort_vld && rdy) begin
                ev = (exp_q.size() != 0) ? exp_q.pop_front() : -1;
                checks++;
                if (int'(sort_data) !== ev) begin
                    $display("FAIL %s stream got %0d want %0d", name, sort_data, ev);
                end else passes++;
            end
            pv = sort_vld;
            pr = rdy;
            pd = sort_data;
            if (done) begin
                done_n = n;
                checks++;
                if (busy !== 1'b1) begin
                    $display("FAIL %s busy_at_done got %b want 1", name, busy);
                end else passes++;
            end
        end
        start = 1'b0;
        rdy = 1'b1;
        checks++;
        if (done_n < 0) begin
            $display("FAIL %s done_timeout got none within %0d cycles want done", name, budget);
        end else passes++;
        if (!rnd_rdy) begin
            checks++;
            if (done_n != exp_done) begin
                $display("FAIL %s done_cycle got T+%0d want T+%0d", name, done_n, exp_done);
            end else passes++;
        end
        checks++;
        if (exp_q.size() != 0 || exp_rd != 16) begin
            $display("FAIL %s completeness got left=%0d reads=%0d want left=0 reads=16",
                     name, exp_q.size(), exp_rd);
        end else passes++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL %s after_done got done=%b busy=%b want 0 0", name, done, busy);
        end else passes++;
    endtask

    task automatic clear_counts();
        for (int v = 0; v < 16; v++) cnt_mem[v] = 16'd0;
    endtask

    task automatic set_sparse();
        clear_counts();
        cnt_mem[3]  = 16'd2;
        cnt_mem[7]  = 16'd1;
        cnt_mem[15] = 16'd3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        rdy = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("idle_no_start");
    endtask

    task automatic test_all_zero();
        clear_counts();
        run_scan("all_zero", 1'b0, -1);
    endtask

    task automatic test_sparse();
        set_sparse();
        run_scan("sparse", 1'b0, -1);
    endtask

    task automatic test_sparse_stall();
        set_sparse();
        run_scan("sparse_stall", 1'b1, -1);
    endtask

    task automatic test_random_counts();
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 16; v++) cnt_mem[v] = 16'($urandom_range(0, 4));
            run_scan("random_counts", r[0], -1);
        end
    endtask

    task automatic test_restart();
        set_sparse();
        run_scan("restart_rd", 1'b0, 5);
        run_scan("restart_emit", 1'b0, 9);
    endtask

    task automatic test_mid_reset();
        int n = 0;
        set_sparse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!sort_vld && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sort_vld !== 1'b1) begin
            $display("FAIL mid_reset reach_emit got vld=%b want 1", sort_vld);
        end else passes++;
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_reset");
        rst = 1'b0;
        run_scan("after_reset", 1'b0, -1);
    endtask

    task automatic test_max_count();
        clear_counts();
        cnt_mem[0] = 16'hFFFF;
        run_scan("max_count", 1'b0, -1);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        rdy = 1'b1;
        test_reset();
        test_all_zero();
        test_sparse();
        test_sparse_stall();
        test_random_counts();
        test_restart();
        test_mid_reset();
        test_max_count();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sort_out_agu.md
# sort_out_agu

Read-out address generator and value reconstructor for the counting-sort engine; the inverse of the input AGU. On `start_i` it walks every value `v = 0 .. SORT_FUC_MAX_NUM-1` in ascending order. For each value it issues a count-memory read at bank `v[BK_DEPTH_W-1:0]`, row `v[DATA_W-1:BK_DEPTH_W]`, then emits `v` on the sorted-output stream as many times as the returned count. It sits between the banked count memory and the downstream sorted-data consumer.

## Interface
Parameters:
- `SORT_FUC_MAX_NUM`, default `` `SORT_FUC_MAX_NUM ``: value range, power of two.
- `SORT_FUC_BK_NUM`, default `` `SORT_FUC_BK_NUM ``: count-memory banks, power of two.
- `SORT_FUC_CNT_W`, default 16: count-memory entry width.
- `SORT_FUC_CNT_MEM_DEPTH_W`, default `$clog2(MAX_NUM/BK_NUM)`: row-address width.
- `SORT_FUC_DATA_W`, default `$clog2(MAX_NUM)`: value width.
- `SORT_FUC_BK_DEPTH_W`, default `$clog2(BK_NUM)`: bank-id width.

Ports:
- `clk_i`  in  1  clock. One clock only; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  single-cycle start pulse.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle pulse at end of scan.
- `out2cnt_vld_o`  out  1  count-memory read strobe.
- `out2cnt_addr_o`  out  CNT_MEM_DEPTH_W  row address, equal to `v[DATA_W-1:BK_DEPTH_W]`.
- `out2cnt_bankid_o`  out  BK_DEPTH_W  bank, equal to `v[BK_DEPTH_W-1:0]`.
- `cnt_rdata_i`  in  CNT_W  count for the read issued the previous cycle (fixed 1-cycle latency).
- `sort_vld_o`  out  1  sorted-value valid.
- `sort_data_o`  out  DATA_W  sorted value.
- `sort_rdy_i`  in  1  downstream ready.

## Operation
- State: FSM {IDLE, RD, WAIT, EMIT, DONE}; value counter `v` (DATA_W bits); remaining counter `rem` (CNT_W bits).
- IDLE:
  - `start_i` → RD, `v`=0.
  - All other inputs are ignored.
- RD:
  - `out2cnt_vld_o`=1, with addr/bankid decoded from `v`.
  - Next state is always WAIT.
- WAIT:
  - Capture `rem` ← `cnt_rdata_i`.
  - Nonzero count → EMIT.
  - Zero count → next value: RD with `v+1`, or DONE if `v`==MAX_NUM-1.
- EMIT:
  - `sort_vld_o`=1, `sort_data_o`=`v`.
  - A handshake is a cycle with vld and rdy both high. Each handshake decrements `rem`.
  - A handshake with `rem`==1 moves to the next value, with the same rule as a zero count.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- `start_i` in any non-IDLE state is ignored; a scan is never restarted.
- `sort_data_o` is held stable, and `sort_vld_o` is never withdrawn, while `sort_rdy_i`=0.
- No wrap of `v` past MAX_NUM-1. The last-value compare is on the full DATA_W width.
- Count-memory contents are never written by this block.

## Timing
- All outputs are decoded from registered state and counters. There is no combinational path from `sort_rdy_i` or `start_i` to any output.
- Reset values:
  - state=IDLE; `v`=0; `rem`=0.
  - `busy_o`, `done_o`, `out2cnt_vld_o`, `sort_vld_o` = 0.
  - `out2cnt_addr_o`, `out2cnt_bankid_o`, `sort_data_o` = 0.
- Start latency: `start_i` in cycle T → RD (read strobe) in T+1 → WAIT in T+2 → first `sort_vld_o` no earlier than T+3.
- Each zero-count value costs exactly 2 cycles (RD, WAIT). A value with count c costs 2 + c cycles at full throughput (one output per cycle while rdy=1).
- `done_o` is asserted the cycle after the final WAIT or final EMIT handshake. `busy_o` falls the cycle after `done_o`.
- Reset mid-scan: the next cycle is IDLE with all outputs at reset values. Any in-flight read data is discarded.
- Max count (2^CNT_W-1) emits exactly that many values. There is no overflow.

## Structure
- The shared sort package holds the width derivations (DATA_W, CNT_MEM_DEPTH_W, BK_DEPTH_W) and the FSM state enum. The same derivations are used by the input AGU.
- One natural sub-module: `sort_val_split`. It is the combinational value→{row, bank} decode, shared with the input-side address generation.
- Everything else (FSM, `v`/`rem` counters) lives in a single module.

## Test plan
All cases use MAX_NUM=16, BK_NUM=4 and a 1-cycle-latency count-memory model.
- All counts 0, start at T → 16 reads (bankid cycling 0,1,2,3, addr 0..3), no `sort_vld_o`, `done_o` at T+33.
- Counts {v3:2, v7:1, v15:3}, rdy held 1 → stream 3,3,7,15,15,15 in order, then `done_o`. Read for v=15 has addr=3, bank=3.
- Same counts, rdy toggled 1/0 randomly → identical stream; data stable and vld held during every rdy=0 cycle.
- Count[0]=65535 (CNT_W=16) → exactly 65535 outputs of value 0 before the read for v=1.
- `start_i` re-pulsed mid-scan → ignored; stream and `done_o` timing unchanged.
- `rst_i` asserted during EMIT → next cycle: all outputs 0, IDLE; a fresh start runs a complete scan from v=0.
